bcd_to_bin_3dig: RTL

BCD_TO_BIN_3DIG -- requirements
Module: bcd_to_bin_3dig

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_mac10.sv | 29 ++
 rtl/bcd_to_bin_3dig.sv | 109 ++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the 3-digit BCD to binary converter.
package bcd_pkg;

   localparam int unsigned BCD_DIGIT_W = 4;
   localparam int unsigned NDIG_DEF    = 3;
   localparam int unsigned BW_DEF      = 10;

   typedef enum logic [1:0] {
      StIdle,
      StConv,
      StDone
   } state_e;

endpackage

// File: rtl/bcd_mac10.sv
// Combinational multiply-by-ten-and-add step for one BCD digit.
module bcd_mac10
   import bcd_pkg::*;
#(
   parameter int unsigned BW = BW_DEF
) (
   input  logic [BW-1:0]          acc_i,
   input  logic [BCD_DIGIT_W-1:0] digit_i,
   output logic [BW-1:0]          acc_o,
   output logic                   digit_bad_o
);

   localparam int unsigned WW = BW + 4;

   logic [WW-1:0] acc_w;
   logic [WW-1:0] prod_w;
   logic [WW-1:0] sum_w;

   // acc*10 as (acc<<3)+(acc<<1) in a widened datapath, truncated on output
   always_comb begin
      acc_w  = WW'(acc_i);
      prod_w = (acc_w << 3) + (acc_w << 1);
      sum_w  = prod_w + WW'(digit_i);
   end

   assign acc_o       = BW'(sum_w);
   assign digit_bad_o = (digit_i > BCD_DIGIT_W'(9));

endmodule

// File: rtl/bcd_to_bin_3dig.sv
// Multi-cycle BCD to binary converter: one digit per cycle, valid/ready on both sides.
module bcd_to_bin_3dig
   import bcd_pkg::*;
#(
   parameter int unsigned NDIG = NDIG_DEF,
   parameter int unsigned BW   = BW_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [NDIG*BCD_DIGIT_W-1:0]   in_bcd,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [BW-1:0]                 bin_out,
   output logic                          err
);

   localparam int unsigned SrW  = NDIG * BCD_DIGIT_W;
   localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;

   state_e              state_q, state_d;
   logic [SrW-1:0]      sr_q, sr_d;
   logic [BW-1:0]       acc_q, acc_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                sticky_q, sticky_d;
   logic [BW-1:0]       bin_q, bin_d;
   logic                err_q, err_d;

   logic [BCD_DIGIT_W-1:0] digit;
   logic [BW-1:0]          mac_acc;
   logic                   digit_bad;

   assign digit = sr_q[SrW-1 -: BCD_DIGIT_W];

   bcd_mac10 #(
      .BW (BW)
   ) u_mac (
      .acc_i       (acc_q),
      .digit_i     (digit),
      .acc_o       (mac_acc),
      .digit_bad_o (digit_bad)
   );

   always_comb begin
      state_d  = state_q;
      sr_d     = sr_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      bin_d    = bin_q;
      err_d    = err_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               sr_d     = in_bcd;
               acc_d    = '0;
               cnt_d    = '0;
               sticky_d = 1'b0;
               state_d  = StConv;
            end
         end
         StConv: begin
            acc_d    = mac_acc;
            sr_d     = sr_q << BCD_DIGIT_W;
            sticky_d = sticky_q | digit_bad;
            cnt_d    = cnt_q + CntW'(1);
            if (cnt_q == CntW'(NDIG - 1)) begin
               // Result registers only change here, so they hold outside DONE
               bin_d   = sticky_d ? '0 : mac_acc;
               err_d   = sticky_d;
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         sr_q     <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         sticky_q <= 1'b0;
         bin_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
         bin_q    <= bin_d;
         err_q    <= err_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign bin_out   = bin_q;
   assign err       = err_q;

endmodule
